uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer placed directly downstream of Top_Module_RX. It captures each byte presented on rhr_data when data_ready rises, and stores it in a first-word-fall-through FIFO. It exposes a pop handshake, occupancy, a threshold interrupt and a sticky overrun flag to the host or register interface. It decouples the host from the single-entry receiver holding register, so back-to-back UART frames are not lost.

Parameters:
DATA_W, 8, byte width; must match rhr_data.
DEPTH, 16, number of FIFO entries; power of 2, minimum 2.
THRESHOLD, 8, rx_irq asserts when count >= THRESHOLD; range 1..DEPTH.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
reset  input  1  synchronous, active-high reset.
rhr_data  input  DATA_W  received byte from Top_Module_RX.
data_ready  input  1  receiver byte-valid; level signal that may stay high for many cycles.
rd_en  input  1  pop request from the host.
rd_data  output  DATA_W  head-of-FIFO byte (FWFT).
empty  output  1  FIFO holds 0 entries.
full  output  1  FIFO holds DEPTH entries.
count  output  $clog2(DEPTH+1)  current occupancy.
rx_irq  output  1  count >= THRESHOLD.
overrun  output  1  sticky flag: at least one byte was dropped.
clr_overrun  input  1  clears overrun.

Behaviour:
- Reset (synchronous, active-high), including mid-operation:
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rx_irq=0, overrun=0, data_ready_q=0, rd_data=0.
  - FIFO contents are flushed; memory array is not reset.
- Write event: data_ready=1 and data_ready_q=0, sampled at a clock edge. Exactly one write per rising edge of data_ready, however long it stays high.
  - data_ready_q is registered every cycle.
  - rhr_data is captured on that same edge.
- Write when not full (or full with a simultaneous valid pop): mem[wr_ptr] <= rhr_data; wr_ptr increments.
- Write when full and no pop: byte is dropped, overrun <= 1, pointers and count unchanged.
- Pop: rd_en=1 and empty=0 → rd_ptr increments. rd_en while empty is ignored and is not an error.
- Pointers wrap from DEPTH-1 to 0. Pointer width is $clog2(DEPTH).
- count update per cycle:
  - +1 on write only.
  - −1 on pop only.
  - unchanged on simultaneous write and pop, or on neither.
- Flags are registered and derived from the next-state count:
  - empty = (count==0).
  - full = (count==DEPTH).
  - rx_irq = (count >= THRESHOLD).
- rd_data = mem[rd_ptr] when empty=0, else 0. Combinational from registered state.
- Latency: a byte whose write event is at edge N is visible on rd_data, with empty=0, immediately after edge N.
- A popped entry is removed at the edge where rd_en is sampled. The next entry (or 0) appears after that edge.
- Simultaneous write and pop while empty: pop ignored, write taken, count becomes 1.
- Simultaneous write and pop while full: both taken, count stays DEPTH, no overrun.
- overrun precedence: a set in the same cycle as clr_overrun wins, so overrun stays 1. Otherwise clr_overrun clears it.
- No state machine beyond the edge detector. All outputs are glitch-free registered state, except rd_data (mux from registered state).

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W=8.
  - UART_RX_FIFO_DEPTH=16.
  - UART_RX_FIFO_THRESH=8.
  - a count-width helper constant.
- One sub-module, rise_detect: clk, reset, in, pulse. Registered delay plus AND-NOT. Reusable for the TX-side start strobe.
- The storage array, pointers and flags stay in uart_rx_fifo.

Test Plan:
1. Reset, then three data_ready rising edges with rhr_data 0xAA, 0x55, 0x0F, data_ready held high 5 cycles each → count=3, empty=0, rd_data=0xAA; three pops return 0xAA, 0x55, 0x0F, then empty=1, rd_data=0.
2. Write 16 bytes 0x00..0x0F → full=1, rx_irq=1 from the 8th write; a 17th write of 0xFF → overrun=1, count=16, data unchanged; drain returns 0x00..0x0F in order.
3. With count=16, write 0xEE and pop in the same cycle → count=16, overrun=0; the last popped entry is 0xEE after the other 15.
4. Empty FIFO, pop plus write 0x3C in the same cycle → count=1, rd_data=0x3C; pop with empty=1 → no change.
5. Sequence of 40 writes interleaved with pops, keeping count ≤ 10 → pointer wrap exercised; output order matches a scoreboard; rx_irq toggles at count 8.
6. count=5 with overrun=1, assert reset for 1 cycle → next cycle count=0, empty=1, overrun=0, rd_data=0; assert clr_overrun during an overflowing write → overrun stays 1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART widths, RX FIFO sizing and the count-width helper
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;
  localparam int UART_RX_FIFO_THRESH = 8;
  localparam int UART_RX_FIFO_CNT_W = $clog2(UART_RX_FIFO_DEPTH + 1);
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: RX FIFO bus; host side (master) drives rhr_data/data_ready/rd_en/clr_overrun, FIFO side (slave) drives rd_data/empty/full/count/rx_irq/overrun
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH = UART_RX_FIFO_DEPTH
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DATA_W-1:0] rhr_data;
  logic data_ready;
  logic rd_en;
  logic clr_overrun;
  logic [DATA_W-1:0] rd_data;
  logic empty;
  logic full;
  logic [CW-1:0] count;
  logic rx_irq;
  logic overrun;
  modport master (
    output rhr_data, data_ready, rd_en, clr_overrun,
    input rd_data, empty, full, count, rx_irq, overrun
  );
  modport slave (
    input rhr_data, data_ready, rd_en, clr_overrun,
    output rd_data, empty, full, count, rx_irq, overrun
  );
endinterface

// File: rtl/rise_detect.sv
// rise_detect: one-cycle pulse on each rising edge of in (ports clk, reset, in, pulse)
module rise_detect (
  input logic clk,
  input logic reset,
  input logic in,
  output logic pulse
);
  logic in_q;
  always_ff @(posedge clk)
    in_q <= reset ? 1'b0 : in;
  assign pulse = in & ~in_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT byte FIFO behind the UART receiver (ports clk, reset, bus: rhr_data/data_ready in, rd_en pop, rd_data/empty/full/count/rx_irq/overrun out, clr_overrun)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int THRESHOLD = UART_RX_FIFO_THRESH
) (
  input logic clk,
  input logic reset,
  uart_rx_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic empty, full, rx_irq, overrun;
  logic wr_ev, pop, take, drop;
  rise_detect u_rise (
    .clk(clk),
    .reset(reset),
    .in(bus.data_ready),
    .pulse(wr_ev)
  );
  always_comb begin
    pop = bus.rd_en & ~empty;
    take = wr_ev & (~full | pop);
    drop = wr_ev & full & ~pop;
    count_n = count + CW'(take) - CW'(pop);
  end
  always_ff @(posedge clk)
    if (take) mem[wr_ptr] <= bus.rhr_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      rx_irq <= 1'b0;
      overrun <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(take);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count_n;
      empty <= count_n == '0;
      full <= count_n == CW'(DEPTH);
      rx_irq <= count_n >= CW'(THRESHOLD);
      overrun <= drop | (overrun & ~bus.clr_overrun);
    end
  end
  assign bus.rd_data = empty ? '0 : mem[rd_ptr];
  assign bus.empty = empty;
  assign bus.full = full;
  assign bus.count = count;
  assign bus.rx_irq = rx_irq;
  assign bus.overrun = overrun;
endmodule
